// File: rtl/rc5_key_schedule.sv
// RC5-w/r/b key expansion engine: packs the secret key into L, fills S from the
// Pw/Qw constants, runs the 3*max(t,c) mixing pass and serves S on a read port.
module rc5_key_schedule #(
  parameter int          w        = 32,
  parameter int          u        = 4,
  parameter int          lg_w     = 5,
  parameter int          b        = 16,
  parameter int          b_length = 4,
  parameter int          t        = 26,
  parameter int          t_length = 5,
  parameter int          c        = 4,
  parameter int          c_length = 2,
  parameter logic [w-1:0] P_W     = 32'hB7E15163,
  parameter logic [w-1:0] Q_W     = 32'h9E3779B9
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                start,
  input  logic [8*b-1:0]      key,
  output logic                busy,
  output logic                done,
  input  logic [t_length-1:0] s_rd_addr,
  output logic [w-1:0]        s_rd_data
);

  localparam int N_MIX = 3 * ((t > c) ? t : c);
  localparam int CNT_W = $clog2(N_MIX);

  typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX, FIN} state_e;

  state_e                state_q, state_d;
  logic [b_length-1:0]   k_q, k_d;
  logic [t_length-1:0]   i_q, i_d;
  logic [c_length-1:0]   j_q, j_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [w-1:0]          a_q, a_d, b_q, b_d;
  logic [w-1:0]          l_q [c];
  logic [w-1:0]          l_d [c];
  logic [w-1:0]          s_q [t];
  logic [w-1:0]          s_d [t];
  logic                  busy_q, busy_d, done_q, done_d;
  logic [w-1:0]          s_rd_data_q, s_rd_data_d;

  logic [c_length-1:0]   l_idx;
  logic [w-1:0]          mix_a, mix_ab, mix_b;

  function automatic logic [w-1:0] rotl(input logic [w-1:0] x, input logic [lg_w-1:0] r);
    logic [2*w-1:0] dbl;
    dbl = {x, x} << r;
    return dbl[2*w-1:w];
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    l_d     = l_q;
    s_d     = s_q;

    l_idx  = c_length'(k_q >> $clog2(u));
    // Both halves of a mixing round are chained combinationally in one cycle.
    mix_a  = rotl(s_q[i_q] + a_q + b_q, lg_w'(3));
    mix_ab = mix_a + b_q;
    mix_b  = rotl(l_q[j_q] + mix_ab, mix_ab[lg_w-1:0]);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          k_d     = b_length'(b - 1);
          a_d     = '0;
          b_d     = '0;
          l_d     = '{default: '0};
        end
      end
      LOAD: begin
        // Highest byte first, so byte 0 ends up in the least significant lane.
        l_d[l_idx] = {l_q[l_idx][w-9:0], key[8*k_q +: 8]};
        k_d        = k_q - 1'b1;
        if (k_q == '0) begin
          state_d = INIT;
          i_d     = '0;
        end
      end
      INIT: begin
        if (i_q == '0) s_d[i_q] = P_W;
        else           s_d[i_q] = s_q[i_q - 1'b1] + Q_W;
        i_d = i_q + 1'b1;
        if (i_q == t_length'(t - 1)) begin
          state_d = MIX;
          i_d     = '0;
          j_d     = '0;
          cnt_d   = '0;
          a_d     = '0;
          b_d     = '0;
        end
      end
      MIX: begin
        s_d[i_q] = mix_a;
        l_d[j_q] = mix_b;
        a_d      = mix_a;
        b_d      = mix_b;
        i_d      = (i_q == t_length'(t - 1)) ? '0 : i_q + 1'b1;
        j_d      = (j_q == c_length'(c - 1)) ? '0 : j_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_MIX - 1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD) || (state_d == INIT) || (state_d == MIX);
    done_d = (state_d == FIN);

    // The table stays hidden while any run is in progress.
    s_rd_data_d = '0;
    if (!busy_q && (int'(s_rd_addr) < t)) s_rd_data_d = s_q[s_rd_addr];
  end

  // NOTE: L and S are register arrays with a defined reset, so a reset mid-run wipes the table.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      l_q         <= '{default: '0};
      s_q         <= '{default: '0};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s_rd_data_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      l_q         <= l_d;
      s_q         <= s_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s_rd_data_q <= s_rd_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign s_rd_data = s_rd_data_q;

endmodule
